// File: rtl/ldl_round_age.sv
// ldl_round_age
//   Priority-class ager that sits upstream of the round-robin arbiter.
//   If a requester waits without a grant, its class is raised by one
//   every AGE_STEP cycles. The boost stops at the top class, so a
//   low-class requester cannot starve.
//
//   Ports
//     clk      clock
//     rst      synchronous reset, active-high
//     req      request vector; the same vector also drives the arbiter
//     cos_in   base class per requester
//     ack      arbiter grant valid
//     hot      arbiter one-hot grant (ignored while ack=0)
//     cos_out  aged class per requester, fed to the arbiter cos input
//     aged     per-requester flag: boost is nonzero
//     starve   (only with LDL_ROUND_AGE_STARVE_EN) sticky flag, set after
//              a full AGE_STEP spent at the top class without a grant
//
//   Build option
//     LDL_ROUND_AGE_STARVE_EN  adds the starve output and its logic
module ldl_round_age #(
  parameter int BIN_WIDTH = 3,
  parameter int REQ_WIDTH = 1 << BIN_WIDTH,
  parameter int COS_WIDTH = 2,
  parameter int AGE_STEP  = 16,
  parameter int AGE_WIDTH = $clog2(AGE_STEP)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [REQ_WIDTH-1:0]                 req,
  input  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0]  cos_in,
  input  logic                                 ack,
  input  logic [REQ_WIDTH-1:0]                 hot,
  output logic [REQ_WIDTH-1:0][COS_WIDTH-1:0]  cos_out,
  output logic [REQ_WIDTH-1:0]                 aged
`ifdef LDL_ROUND_AGE_STARVE_EN
  ,
  output logic [REQ_WIDTH-1:0]                 starve
`endif
);

  localparam logic [COS_WIDTH-1:0] COS_MAX   = '1;
  localparam logic [AGE_WIDTH-1:0] WAIT_LAST = AGE_WIDTH'(AGE_STEP - 1);

  logic [REQ_WIDTH-1:0][AGE_WIDTH-1:0] wait_cnt;
  logic [REQ_WIDTH-1:0][COS_WIDTH-1:0] boost;
  logic [REQ_WIDTH-1:0]                grant;

  assign grant = {REQ_WIDTH{ack}} & hot;

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      boost    <= '0;
`ifdef LDL_ROUND_AGE_STARVE_EN
      starve   <= '0;
`endif
    end else begin
      for (int i = 0; i < REQ_WIDTH; i++) begin
        if (!req[i] || grant[i]) begin
          // A dropped request gives up its aging. A grant clears it, even
          // when a step event lands in the same cycle.
          wait_cnt[i] <= '0;
          boost[i]    <= '0;
`ifdef LDL_ROUND_AGE_STARVE_EN
          starve[i]   <= 1'b0;
`endif
        end else if (wait_cnt[i] == WAIT_LAST) begin
          // At saturation the counter keeps wrapping and boost holds.
          wait_cnt[i] <= '0;
          if (boost[i] != COS_MAX) begin
            boost[i] <= boost[i] + 1'b1;
          end
`ifdef LDL_ROUND_AGE_STARVE_EN
          else begin
            starve[i] <= 1'b1;
          end
`endif
        end else begin
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
        end
      end
    end
  end

  // cos_out depends only on registered boost and cos_in. There is no path
  // from req/ack, which keeps the loop through the arbiter free of
  // combinational cycles.
  for (genvar g = 0; g < REQ_WIDTH; g++) begin : g_out
    logic [COS_WIDTH:0] sum;
    assign sum        = {1'b0, cos_in[g]} + {1'b0, boost[g]};
    assign cos_out[g] = sum[COS_WIDTH] ? COS_MAX : sum[COS_WIDTH-1:0];
    assign aged[g]    = |boost[g];
  end

endmodule

// File: tb/tb_ldl_round_age.sv
module tb_ldl_round_age;

  localparam int AGE  = 16;
  localparam int MAXC = 3;

  logic            clk;
  logic            rst;
  logic [7:0]      req;
  logic [7:0][1:0] cos_in;
  logic            ack;
  logic [7:0]      hot;
  logic [7:0][1:0] cos_out;
  logic [7:0]      aged;
  logic [7:0]      starve;

  ldl_round_age dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .cos_in  (cos_in),
    .ack     (ack),
    .hot     (hot),
    .cos_out (cos_out),
    .aged    (aged)
`ifdef LDL_ROUND_AGE_STARVE_EN
    ,
    .starve  (starve)
`endif
  );

`ifndef LDL_ROUND_AGE_STARVE_EN
  initial starve = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][1:0] cos;
    logic [7:0]      aged;
    logic [7:0]      starve;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  // Reference model: how many consecutive unserved request cycles each
  // requester has seen. The class boost and the starvation flag follow
  // from this count by plain arithmetic.
  int   run_len [8];
  bit   model_valid = 0;
  logic [7:0][1:0] ci;

  function automatic int boost_of(input int n);
    return (n / AGE > MAXC) ? MAXC : n / AGE;
  endfunction

  task automatic chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Drive one cycle, push the expected outputs for that cycle, then
  // advance the model across the clock edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic a, input logic [7:0] h);
    exp_t e;
    int   s;
    rst = r; req = rq; ack = a; hot = h; cos_in = ci;
    if (model_valid) begin
      for (int i = 0; i < 8; i++) begin
        s = int'(ci[i]) + boost_of(run_len[i]);
        e.cos[i]    = 2'((s > MAXC) ? MAXC : s);
        e.aged[i]   = (boost_of(run_len[i]) != 0);
        e.starve[i] = (run_len[i] >= (MAXC + 1) * AGE);
      end
      exp_q.push_back(e);
    end
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      if (r || !rq[i] || (a && h[i])) run_len[i] = 0;
      else if (run_len[i] < 100000) run_len[i] = run_len[i] + 1;
    end
    if (r) model_valid = 1;
    #1;
  endtask

  task automatic run(input int n, input logic [7:0] rq, input logic a, input logic [7:0] h);
    for (int k = 0; k < n; k++) step(1'b0, rq, a, h);
  endtask

  task automatic do_reset();
    step(1'b1, 8'h00, 1'b0, 8'h00);
    step(1'b1, 8'h00, 1'b0, 8'h00);
  endtask

  // Monitor: pops one expectation per cycle and compares mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      tests++;
      if (cos_out !== e.cos || aged !== e.aged) begin
        errors++;
        $display("FAIL sb_out: cos_out=%h aged=%h, expected cos_out=%h aged=%h",
                 cos_out, aged, e.cos, e.aged);
      end
`ifdef LDL_ROUND_AGE_STARVE_EN
      tests++;
      if (starve !== e.starve) begin
        errors++;
        $display("FAIL sb_starve: got %h, expected %h", starve, e.starve);
      end
`endif
    end
  end

  initial begin
    logic [7:0] rq;
    logic       a;
    logic [7:0] h;
    logic       r;
    int         drain;

    for (int i = 0; i < 8; i++) run_len[i] = 0;
    ci = '0;
    rst = 1'b1; req = '0; ack = 1'b0; hot = '0; cos_in = '0;

    // Reset state and a long single-requester wait
    do_reset();
    chk("rst_aged", int'(aged), 0);
    chk("rst_cos", int'(cos_out), 0);
    for (int k = 1; k <= 100; k++) begin
      step(1'b0, 8'h01, 1'b0, 8'h00);
      if (k == 15)  chk("age_c15", int'(cos_out[0]), 0);
      if (k == 16)  chk("age_c16", int'(cos_out[0]), 1);
      if (k == 16)  chk("aged_c16", int'(aged[0]), 1);
      if (k == 31)  chk("age_c31", int'(cos_out[0]), 1);
      if (k == 32)  chk("age_c32", int'(cos_out[0]), 2);
      if (k == 48)  chk("age_c48", int'(cos_out[0]), 3);
      if (k == 100) chk("age_c100", int'(cos_out[0]), 3);
    end

    // A grant clears the boost, and aging restarts from zero
    do_reset();
    run(20, 8'h04, 1'b0, 8'h00);
    chk("gnt_pre", int'(cos_out[2]), 1);
    run(1, 8'h04, 1'b1, 8'h04);
    chk("gnt_cos", int'(cos_out[2]), 0);
    chk("gnt_aged", int'(aged[2]), 0);
    run(15, 8'h04, 1'b0, 8'h00);
    chk("gnt_re15", int'(aged[2]), 0);
    run(1, 8'h04, 1'b0, 8'h00);
    chk("gnt_re16", int'(aged[2]), 1);

    // A grant wins over a step event in the same cycle
    do_reset();
    run(15, 8'h08, 1'b0, 8'h00);
    run(1, 8'h08, 1'b1, 8'h08);
    chk("tie_aged", int'(aged[3]), 0);
    run(15, 8'h08, 1'b0, 8'h00);
    chk("tie_15", int'(aged[3]), 0);
    run(1, 8'h08, 1'b0, 8'h00);
    chk("tie_16", int'(aged[3]), 1);

    // The aged class is clamped at the top class
    do_reset();
    ci[1] = 2'd2;
    run(16, 8'h02, 1'b0, 8'h00);
    chk("clamp_b1", int'(cos_out[1]), 3);
    run(16, 8'h02, 1'b0, 8'h00);
    chk("clamp_b2", int'(cos_out[1]), 3);
    chk("clamp_aged", int'(aged[1]), 1);
    ci = '0;

    // Dropping a request forfeits its aging; hot with ack=0 is ignored
    do_reset();
    run(10, 8'h20, 1'b0, 8'h00);
    run(1, 8'h00, 1'b0, 8'h00);
    run(15, 8'h20, 1'b0, 8'h00);
    chk("drop_15", int'(aged[5]), 0);
    run(1, 8'h20, 1'b0, 8'h00);
    chk("drop_16", int'(aged[5]), 1);
    run(1, 8'h20, 1'b0, 8'h20);
    chk("hot_noack", int'(aged[5]), 1);

`ifdef LDL_ROUND_AGE_STARVE_EN
    do_reset();
    run(63, 8'h01, 1'b0, 8'h00);
    chk("starve_63", int'(starve[0]), 0);
    run(1, 8'h01, 1'b0, 8'h00);
    chk("starve_64", int'(starve[0]), 1);
    run(1, 8'h01, 1'b1, 8'h01);
    chk("starve_clr", int'(starve[0]), 0);
`endif

    // Random traffic against the model
    do_reset();
    rq = 8'h00;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < 8; i++)
        if ($urandom_range(0, 15) == 0) rq[i] = ~rq[i];
      a = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 3) == 0) h = 8'($urandom);
      else h = 8'h01 << $urandom_range(0, 7);
      if ($urandom_range(0, 31) == 0) ci = 16'($urandom);
      r = ($urandom_range(0, 599) == 0);
      step(r, rq, a, h);
    end

    drain = 0;
    while (exp_q.size() != 0 && drain < 5) begin
      @(posedge clk);
      drain++;
    end
    chk("sb_drain", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
